trig_capture_core: RTL and testbench
====================================

Name: trig_capture_core

Overview:
Parametrised successor to the single-channel trigger/delay/waveform path in the ADC domain.
- Captures NUM_CH ADC channels into per-channel circular buffers.
- Programmable pre-trigger depth, level/slope trigger on any selected channel, forced trigger, abort.
- Freezes the record and exposes a random-access readout port with an explicit release handshake to the Nios PIO bridge.
- Sits between the adc_sync outputs and the sample-readout logic.

Parameters:
NUM_CH, 2, number of ADC channels captured in lockstep
DATA_W, 14, sample width (offset binary, unsigned)
DEPTH, 1024, samples per channel per record; must be a power of two
ADDR_W, $clog2(DEPTH), buffer address width (derived)
CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), channel select width (derived)

Ports:
sys_clk  in  1  ADC-domain clock, all logic rising edge
reset_n  in  1  asynchronous active-low reset
adc_data  in  NUM_CH*DATA_W  synchronised samples, channel c at [c*DATA_W +: DATA_W]
trig_src  in  CH_W  channel used for level trigger
trig_level  in  DATA_W  trigger threshold
trig_slope  in  1  1 = rising, 0 = falling
pretrig  in  ADDR_W  samples kept before trigger sample
arm  in  1  single-cycle start request
force_trig  in  1  single-cycle software trigger
abort  in  1  single-cycle return to IDLE
busy  out  1  high in PRE, WAIT_TRIG, POST
ready  out  1  high in READY (record frozen)
wave_num  out  16  completed-record counter
rd_ch  in  CH_W  readout channel
rd_addr  in  ADDR_W  readout index, 0 = oldest sample of record
rd_data  out  DATA_W  sample, 1-cycle latency
rd_release  in  1  single-cycle: host finished reading

Behaviour:
- Reset: state IDLE, busy=0, ready=0, wave_num=0, rd_data=0, write pointer=0, counters=0. Buffer RAM contents not reset.
- Effective pretrig pe = min(pretrig, DEPTH-1). pretrig, trig_src, trig_level and trig_slope are sampled when arm is accepted and held for the whole record.
- IDLE: arm -> PRE. Buffers are not written.
- PRE: writes every cycle, counting pe samples. Triggers are ignored. Count reaches pe -> WAIT_TRIG; pe=0 -> WAIT_TRIG on the next cycle.
- WAIT_TRIG: writes continuously, ring wraps mod DEPTH.
  - Level trigger rising: prev < level && cur >= level. Falling: prev > level && cur <= level. prev is the previous cycle's sample of the selected channel.
  - A level or force_trig event latches trig_ptr = the write address of the current sample, then -> POST.
- POST: writes DEPTH-pe-1 further samples after the trigger sample, then -> READY. wave_num increments by 1 on the READY entry cycle, wrapping at 16 bits.
- READY: writes stop and pointers freeze.
  - rd_data <= buf[rd_ch][(trig_ptr - pe + rd_addr) mod DEPTH], registered.
  - rd_release -> IDLE.
- Record length is always exactly DEPTH; the trigger sample sits at rd_addr = pe.
- abort in any state -> IDLE next cycle; wave_num is unchanged. abort wins over arm, force_trig and rd_release in the same cycle.
- arm outside IDLE is ignored. rd_release outside READY is ignored.
- rd_data is held stable outside READY.
- Comparisons are unsigned DATA_W, with no sign extension.

Decomposition:
- Package trig_capture_pkg:
  - state enum {IDLE, PRE, WAIT_TRIG, POST, READY}
  - SLOPE_FALL=0, SLOPE_RISE=1
  - default mid-scale level 2**(DATA_W-1)
- Sub-module level_trigger (one instance): registers prev sample; combinational edge compare against level/slope; output pulse.
- Buffers are one inferred simple dual-port RAM per channel, using a generate loop in the core.

Test Plan:
- Ramp 0..16383 on ch0, trig_src=0, level=9400, rise, pretrig=100, DEPTH=1024, arm -> ready after trigger +923 cycles; rd_addr 100 reads 9400, rd_addr 0 reads 9300; wave_num=1.
- Falling trigger, level=7000, ch1 descending ramp, pretrig=0 -> rd_addr 0 reads 7000, rd_addr 1023 reads 5977.
- Level crossing during PRE only, then flat input, force_trig asserted 50 cycles later -> trigger sample is the force_trig cycle sample; no early trigger.
- Trigger occurs after the write pointer wraps (WAIT_TRIG > 2000 cycles) -> record contiguous across address wrap, rd_addr order monotonic for a ramp.
- abort during POST, then arm+abort in the same cycle -> state IDLE, busy=0, wave_num unchanged.
- pretrig=1023 (pe clamp boundary) and rd_release then re-arm 65536 times (or preset counter) -> trigger at rd_addr 1023; wave_num wraps 0xFFFF -> 0x0000.

Source files
------------

// File: rtl/trig_capture_pkg.sv
// Shared types and constants for the multi-channel trigger/capture path.
package trig_capture_pkg;
  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, READY} state_t;

  localparam logic SLOPE_FALL = 1'b0;
  localparam logic SLOPE_RISE = 1'b1;

  // Mid-scale code for an offset-binary sample of width w.
  function automatic int unsigned mid_level(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/level_trigger.sv
// Level/slope crossing detector on one selected channel of the sample bus.
module level_trigger
  import trig_capture_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 14,
  parameter int CH_W   = 1
) (
  input  logic                           sys_clk,
  input  logic                           reset_n,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  samples,
  input  logic [CH_W-1:0]                src,
  input  logic [DATA_W-1:0]              level,
  input  logic                           slope,
  output logic                           hit
);
  logic [DATA_W-1:0] cur, prev;

  assign cur = samples[src];

  always_ff @(posedge sys_clk or negedge reset_n)
    if (!reset_n) prev <= '0;
    else          prev <= cur;

  always_comb begin
    hit = 1'b0;
    if (slope == SLOPE_FALL) hit = (prev > level) && (cur <= level);
    else                     hit = (prev < level) && (cur >= level);
  end
endmodule

// File: rtl/trig_capture_core.sv
// NUM_CH-channel circular capture with pre-trigger depth, level/forced trigger
// and a frozen random-access readout released by the host.
module trig_capture_core
  import trig_capture_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 14,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       sys_clk,
  input  logic                       reset_n,
  input  logic [NUM_CH*DATA_W-1:0]   adc_data,
  input  logic [CH_W-1:0]            trig_src,
  input  logic [DATA_W-1:0]          trig_level,
  input  logic                       trig_slope,
  input  logic [ADDR_W-1:0]          pretrig,
  input  logic                       arm,
  input  logic                       force_trig,
  input  logic                       abort,
  output logic                       busy,
  output logic                       ready,
  output logic [15:0]                wave_num,
  input  logic [CH_W-1:0]            rd_ch,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data,
  input  logic                       rd_release
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] wptr, cnt, trig_ptr, pe_q, post_len, rd_ptr;
  logic [CH_W-1:0]   src_q, rd_ch_q;
  logic [DATA_W-1:0] lvl_q;
  logic              slope_q, hit, wr_en, fire;
  logic [NUM_CH-1:0][DATA_W-1:0] adc_ch, rd_q;

  assign adc_ch   = adc_data;
  // pretrig is ADDR_W wide, so it can never exceed DEPTH-1: no clamp needed.
  assign post_len = ADDR_W'(DEPTH - 1) - pe_q;
  assign wr_en    = state_q inside {PRE, WAIT_TRIG, POST};
  assign fire     = hit | force_trig;
  assign busy     = wr_en;
  assign ready    = (state_q == READY);
  assign rd_ptr   = trig_ptr - pe_q + rd_addr;
  assign rd_data  = rd_q[rd_ch_q];

  level_trigger #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) u_trig (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .samples (adc_ch),
    .src     (src_q),
    .level   (lvl_q),
    .slope   (slope_q),
    .hit     (hit)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (arm) state_d = PRE;
      PRE:       if ((pe_q == '0) || (cnt == pe_q - ADDR_W'(1))) state_d = WAIT_TRIG;
      // With a full-depth pretrigger the trigger sample is the last one.
      WAIT_TRIG: if (fire) state_d = (post_len == '0) ? READY : POST;
      POST:      if (cnt == post_len - ADDR_W'(1)) state_d = READY;
      READY:     if (rd_release) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge sys_clk or negedge reset_n)
    if (!reset_n) begin
      state_q  <= IDLE;
      wptr     <= '0;
      cnt      <= '0;
      trig_ptr <= '0;
      pe_q     <= '0;
      src_q    <= '0;
      lvl_q    <= DATA_W'(mid_level(DATA_W));
      slope_q  <= SLOPE_RISE;
      wave_num <= '0;
      rd_ch_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == PRE) begin
        pe_q    <= pretrig;
        src_q   <= trig_src;
        lvl_q   <= trig_level;
        slope_q <= trig_slope;
      end
      cnt <= (state_d != state_q) ? '0 : cnt + ADDR_W'(1);
      if (wr_en) wptr <= wptr + ADDR_W'(1);
      if (state_q == WAIT_TRIG && fire) trig_ptr <= wptr;
      if (state_d == READY && state_q != READY) wave_num <= wave_num + 16'd1;
      if (ready) rd_ch_q <= rd_ch;
    end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_r;

    always_ff @(posedge sys_clk)
      if (wr_en) mem[wptr] <= adc_ch[c];

    // Read only while frozen so rd_data holds its last value otherwise.
    always_ff @(posedge sys_clk or negedge reset_n)
      if (!reset_n)   rd_r <= '0;
      else if (ready) rd_r <= mem[rd_ptr];

    assign rd_q[c] = rd_r;
  end
endmodule

// File: tb/tb_trig_capture_core.sv
// Randomized scoreboard bench for trig_capture_core against an input-history model.
module tb_trig_capture_core;
  localparam int NUM_CH = 2, DATA_W = 14, DEPTH = 1024, ADDR_W = 10, CH_W = 1;

  logic                     sys_clk, reset_n;
  logic [NUM_CH*DATA_W-1:0] adc_data;
  logic [CH_W-1:0]          trig_src, rd_ch;
  logic [DATA_W-1:0]        trig_level, rd_data;
  logic                     trig_slope, arm, force_trig, abort, busy, ready, rd_release;
  logic [ADDR_W-1:0]        pretrig, rd_addr;
  logic [15:0]              wave_num;

  trig_capture_core #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .adc_data(adc_data), .trig_src(trig_src),
    .trig_level(trig_level), .trig_slope(trig_slope), .pretrig(pretrig), .arm(arm),
    .force_trig(force_trig), .abort(abort), .busy(busy), .ready(ready),
    .wave_num(wave_num), .rd_ch(rd_ch), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_release(rd_release)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_tests = 0, n_fail = 0, wexp = 0, last_exp = 0;
  int h0[$], h1[$];          // per-edge samples seen by the DUT
  bit hf[$];                 // per-edge force_trig
  int exp_q[$], tag_q[$];
  logic rd_req = 1'b0, rd_pend = 1'b0;

  always @(posedge sys_clk) rd_pend <= rd_req;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every read sampled at the previous edge pops one expectation.
  initial begin
    int e, tg;
    forever begin
      @(negedge sys_clk);
      if (rd_pend) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_data: response with empty scoreboard, got %0d", rd_data);
        end else begin
          e  = exp_q.pop_front();
          tg = tag_q.pop_front();
          if (int'(rd_data) !== e) begin
            n_fail++;
            $display("FAIL rd_data ch%0d addr%0d: got %0d expected %0d", tg / 65536, tg % 65536, rd_data, e);
          end
        end
      end
    end
  end

  task automatic tick();
    h0.push_back(int'(adc_data[DATA_W-1:0]));
    h1.push_back(int'(adc_data[2*DATA_W-1:DATA_W]));
    hf.push_back(force_trig);
    @(posedge sys_clk);
    #1;
    arm = 0; force_trig = 0; abort = 0; rd_release = 0; rd_req = 0;
  endtask

  task automatic set_adc(input int v0, input int v1);
    adc_data = {DATA_W'(v1), DATA_W'(v0)};
  endtask

  function automatic int hv(input int ch, input int e);
    if (e < 0 || e >= h0.size()) return -1;
    return (ch != 0) ? h1[e] : h0[e];
  endfunction

  // First edge, from the first post-pretrigger edge on, with a force or a crossing.
  function automatic int find_trig(input int a, input int pe, input int src, input int lvl, input bit slope);
    int w, cur, prv;
    w = a + 1 + ((pe == 0) ? 1 : pe);
    for (int e = w; e < h0.size(); e++) begin
      cur = hv(src, e);
      prv = hv(src, e - 1);
      if (hf[e]) return e;
      if (slope ? (prv < lvl && cur >= lvl) : (prv > lvl && cur <= lvl)) return e;
    end
    return -1;
  endfunction

  function automatic int gen(input int wave, input int ch, input int k);
    case (wave)
      0: return (ch == 0) ? k % 16384 : int'($urandom_range(0, 16383));
      1: return (ch == 1) ? 7500 - k : int'($urandom_range(0, 16383));
      2: return (ch == 0) ? ((k < 150) ? 1000 + 10 * k : 2490) : int'($urandom_range(0, 16383));
      4: return int'($urandom_range(0, 16382));
      default: return int'($urandom_range(0, 16383));
    endcase
  endfunction

  task automatic rd(input int ch, input int addr, input int exp);
    rd_ch = CH_W'(ch);
    rd_addr = ADDR_W'(addr);
    exp_q.push_back(exp);
    tag_q.push_back(ch * 65536 + addr);
    last_exp = exp;
    rd_req = 1;
    tick();
  endtask

  task automatic run_record(input string nm, input int pe, input int src, input int lvl, input bit slope,
                            input int wave, input int force_k, input int nrand, output int t);
    int k, a, rdy_e, ch, addr;
    bit seen;
    pretrig = ADDR_W'(pe); trig_src = CH_W'(src); trig_level = DATA_W'(lvl); trig_slope = slope;
    arm = 1; a = h0.size(); k = 0; seen = 0; rdy_e = -1; t = -1;
    for (int i = 0; i < 20000 && !seen; i++) begin
      set_adc(gen(wave, 0, k), gen(wave, 1, k));
      force_trig = (k == force_k);
      tick();
      k++;
      if (k == 1) begin  // settings must be held from the arm edge
        trig_level = DATA_W'($urandom); pretrig = ADDR_W'($urandom);
        trig_src = CH_W'($urandom); trig_slope = 1'($urandom);
      end
      if (ready) begin seen = 1; rdy_e = h0.size() - 1; end
    end
    if (!seen) begin
      chk({nm, "_ready_timeout"}, 0, 1);
      return;
    end
    t = find_trig(a, pe, src, lvl, slope);
    wexp = (wexp + 1) % 65536;
    chk({nm, "_ready_edge"}, rdy_e, t + DEPTH - 1 - pe);
    chk({nm, "_wave_num"}, int'(wave_num), wexp);
    chk({nm, "_busy"}, int'(busy), 0);
    rd(src, 0, hv(src, t - pe));
    rd(src, pe, hv(src, t));
    rd(1 - src, DEPTH - 1, hv(1 - src, t - pe + DEPTH - 1));
    for (int i = 0; i < nrand; i++) begin
      ch = int'($urandom_range(0, 1));
      addr = int'($urandom_range(0, DEPTH - 1));
      rd(ch, addr, hv(ch, t - pe + addr));
    end
  endtask

  task automatic release_rec(input string nm);
    rd_release = 1;
    tick();
    chk({nm, "_rel_ready"}, int'(ready), 0);
    chk({nm, "_rel_busy"}, int'(busy), 0);
    rd_addr = ADDR_W'($urandom);
    rd_ch = ~rd_ch;
    repeat (3) tick();
    chk({nm, "_rd_hold"}, int'(rd_data), last_exp);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset_n = 0; arm = 0; force_trig = 0; abort = 0; rd_release = 0;
    trig_src = '0; trig_level = '0; trig_slope = 1; pretrig = '0; rd_ch = '0; rd_addr = '0;
    set_adc(0, 0);
    repeat (3) tick();
    chk("reset_busy", int'(busy), 0);
    reset_n = 1;
    chk("reset_ready", int'(ready), 0);
    chk("reset_wave_num", int'(wave_num), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    repeat (2) tick();

    // Rising ramp on ch0
    run_record("ramp_rise", 100, 0, 9400, 1, 0, -1, 8, t);
    rd(0, 100, 9400);
    rd(0, 0, 9300);
    release_rec("ramp_rise");

    // Falling ramp on ch1, no pretrigger
    run_record("ramp_fall", 0, 1, 7000, 0, 1, -1, 8, t);
    rd(1, 0, 7000);
    rd(1, 1023, 5977);
    release_rec("ramp_fall");

    // Crossing only inside the pretrigger window, then forced trigger
    run_record("pre_ignore", 200, 0, 1500, 1, 2, 251, 8, t);
    rd(0, 200, 2490);
    rd(0, 0, 1510);
    release_rec("pre_ignore");

    // Long wait so the write pointer wraps before the trigger
    run_record("wrap", 300, 0, 3000, 1, 0, -1, 4, t);
    for (int i = 0; i < DEPTH; i += 97) rd(0, i, 2700 + i);
    rd(0, 1023, 3723);
    release_rec("wrap");

    // Abort inside POST, then arm together with abort
    pretrig = 3; trig_src = 0; trig_level = 16383; trig_slope = 1;
    arm = 1;
    for (int k = 0; k <= 10; k++) begin
      set_adc(gen(4, 0, k), gen(4, 1, k));
      force_trig = (k == 6);
      abort = (k == 10);
      tick();
    end
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(ready), 0);
    chk("abort_wave_num", int'(wave_num), wexp);
    arm = 1; abort = 1;
    tick();
    chk("arm_abort_busy", int'(busy), 0);
    force_trig = 1; tick();
    rd_release = 1; tick();
    chk("arm_abort_idle", int'(busy), 0);
    chk("arm_abort_wave_num", int'(wave_num), wexp);

    // Randomized records with random settings on noise
    for (int r = 0; r < 3; r++) begin
      int pe;
      pe = int'($urandom_range(0, DEPTH - 1));
      run_record("rand", pe, int'($urandom_range(0, 1)), int'($urandom_range(0, 16383)),
                 1'($urandom), 5, 1 + ((pe == 0) ? 1 : pe) + 400, 16, t);
      release_rec("rand");
    end

    // Full-depth pretrigger and counter wrap from 0xFFFF
    @(negedge sys_clk);
    force dut.wave_num = 16'hFFFF;
    #1;
    release dut.wave_num;
    wexp = 65535;
    run_record("pe_max", 1023, int'($urandom_range(0, 1)), 16383, 1, 4, 1024 + 20, 8, t);
    release_rec("pe_max");

    repeat (3) tick();
    chk("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
